// File: rtl/ber_sweep_ctrl_pkg.sv
// rtl/ber_sweep_ctrl_pkg.sv - sweep state encoding and default datapath widths
package ber_ctrl_pkg;

   localparam int DEF_CNT_W   = 32;
   localparam int DEF_NOISE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      FLUSH,
      MEASURE,
      REPORT
   } state_t;

endpackage

// File: rtl/ber_sweep_ctrl_if.sv
// rtl/ber_sweep_ctrl_if.sv - result record valid/ready channel of the BER sweep sequencer
interface ber_res_if
   import ber_ctrl_pkg::*;
#(
   parameter int PT_W  = 3,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic             res_valid;
   logic             res_ready;
   logic [PT_W-1:0]  res_point;
   logic [CNT_W-1:0] res_bits;
   logic [CNT_W-1:0] res_errors;

   modport master (
      output res_valid, res_point, res_bits, res_errors,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_point, res_bits, res_errors,
      output res_ready
   );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/ber_sweep_ctrl.sv
// rtl/ber_sweep_ctrl.sv - BER sweep sequencer over a noise-level table; BER_EARLY_STOP_EN adds error-count exit
module ber_sweep_ctrl
   import ber_ctrl_pkg::*;
#(
   parameter int MAX_POINTS   = 8,
   parameter int NOISE_W      = DEF_NOISE_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int RST_CYCLES   = 4,
   parameter int FLUSH_CYCLES = 16
`ifdef BER_EARLY_STOP_EN
   , parameter int MAX_ERRORS = 100
`endif
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [$clog2(MAX_POINTS)-1:0] cfg_addr,
   input  logic [NOISE_W-1:0]            cfg_data,
   input  logic [$clog2(MAX_POINTS):0]   num_points,
   input  logic [CNT_W-1:0]              target_bits,
   input  logic                          start,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   output logic                          chain_rst,
   output logic                          chain_en,
   output logic [NOISE_W-1:0]            noise_level,
   input  logic                          rx_bit_valid,
   input  logic                          rx_bit_err,
   ber_res_if.master                     res
);

   localparam int PT_W = $clog2(MAX_POINTS);
   localparam int PH_W = 16;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PT_W-1:0]  PT_ONE     = PT_W'(1);
   localparam logic [PT_W:0]    NPT_ONE    = (PT_W+1)'(1);
   localparam logic [PT_W:0]    NPT_MAX    = (PT_W+1)'(MAX_POINTS);
   localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
   localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0]  FLUSH_LAST = PH_W'(FLUSH_CYCLES - 1);

   state_t             state, state_d;
   logic [PH_W-1:0]    ph_q, ph_d;
   logic [PT_W-1:0]    point_q, point_d;
   logic [PT_W:0]      npts_q, npts_d;
   logic [CNT_W-1:0]   target_q, target_d;
   logic               done_q, done_d;
   logic [NOISE_W-1:0] tbl [MAX_POINTS];

   logic [CNT_W-1:0]   bits, errors;
   logic               bit_inc, err_inc, hit_target, hit_errors, last_point;

   assign bit_inc    = (state == MEASURE) && rx_bit_valid;
   assign err_inc    = bit_inc && rx_bit_err;
   // target_q is never 0, so target_q-1 cannot wrap
   assign hit_target = bit_inc && (bits >= target_q - CNT_ONE);
   assign last_point = ({1'b0, point_q} == npts_q - NPT_ONE);

`ifdef BER_EARLY_STOP_EN
   assign hit_errors = err_inc && (errors >= CNT_W'(MAX_ERRORS) - CNT_ONE);
`else
   assign hit_errors = 1'b0;
`endif

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == FLUSH),
      .inc   (bit_inc),
      .value (bits)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == FLUSH),
      .inc   (err_inc),
      .value (errors)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ph_q     <= '0;
         point_q  <= '0;
         npts_q   <= '0;
         target_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_d;
         ph_q     <= ph_d;
         point_q  <= point_d;
         npts_q   <= npts_d;
         target_q <= target_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_POINTS; i++) tbl[i] <= '0;
      end else if (cfg_we && (state == IDLE)) begin
         tbl[cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      state_d   = state;
      ph_d      = ph_q;
      point_d   = point_q;
      npts_d    = npts_q;
      target_d  = target_q;
      done_d    = 1'b0;
      busy      = (state != IDLE);
      chain_rst = 1'b0;
      chain_en  = 1'b0;

      case (state)
         IDLE: begin
            chain_rst = 1'b1;
            if (start) begin
               target_d = (target_bits == '0) ? CNT_ONE : target_bits;
               npts_d   = (num_points > NPT_MAX) ? NPT_MAX : num_points;
               point_d  = '0;
               ph_d     = '0;
               if (num_points == '0) done_d = 1'b1;
               else                  state_d = RST;
            end
         end
         RST: begin
            chain_rst = 1'b1;
            if (ph_q == RST_LAST) begin
               ph_d    = '0;
               state_d = FLUSH;
            end else begin
               ph_d = ph_q + PH_ONE;
            end
         end
         FLUSH: begin
            chain_en = 1'b1;
            if (ph_q == FLUSH_LAST) begin
               ph_d    = '0;
               state_d = MEASURE;
            end else begin
               ph_d = ph_q + PH_ONE;
            end
         end
         MEASURE: begin
            chain_en = 1'b1;
            if (hit_target || hit_errors) state_d = REPORT;
         end
         REPORT: begin
            if (res.res_ready) begin
               if (last_point) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  point_d = point_q + PT_ONE;
                  ph_d    = '0;
                  state_d = RST;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // abort wins over start, completion and handshake alike
      if (abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   assign done           = done_q;
   assign noise_level    = tbl[point_q];
   assign res.res_valid  = (state == REPORT);
   assign res.res_point  = point_q;
   assign res.res_bits   = bits;
   assign res.res_errors = errors;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// tb/tb_ber_sweep_ctrl.sv - scoreboard bench for the BER sweep sequencer
module tb_ber_sweep_ctrl;

   typedef struct packed {
      logic [2:0]  point;
      logic [31:0] bits;
      logic [31:0] errors;
   } res_t;

   logic        clk, rst, cfg_we, start, abort;
   logic [2:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic [3:0]  num_points;
   logic [31:0] target_bits;
   logic        busy, done, chain_rst, chain_en;
   logic [7:0]  noise_level;
   logic        rx_bit_valid, rx_bit_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int vcnt = 0;
   int rx_mode = 0;
   int done_cnt = 0;
   int rv_cnt = 0;
   res_t sb_q[$];

   ber_res_if #(.PT_W(3), .CNT_W(32)) res_if ();

   ber_sweep_ctrl #(
      .MAX_POINTS(8), .NOISE_W(8), .CNT_W(32), .RST_CYCLES(4), .FLUSH_CYCLES(16)
`ifdef BER_EARLY_STOP_EN
      , .MAX_ERRORS(5)
`endif
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .num_points(num_points), .target_bits(target_bits), .start(start), .abort(abort),
      .busy(busy), .done(done), .chain_rst(chain_rst), .chain_en(chain_en),
      .noise_level(noise_level), .rx_bit_valid(rx_bit_valid), .rx_bit_err(rx_bit_err),
      .res(res_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input int p, input int b, input int e);
      res_t r;
      r.point  = 3'(p);
      r.bits   = 32'(b);
      r.errors = 32'(e);
      sb_q.push_back(r);
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (res_if.res_valid) rv_cnt++;
      if (res_if.res_valid && res_if.res_ready) begin
         check_eq("sb_expected_result", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            res_t e;
            e = sb_q.pop_front();
            check_eq("res_point", 64'(res_if.res_point), 64'(e.point));
            check_eq("res_bits", 64'(res_if.res_bits), 64'(e.bits));
            check_eq("res_errors", 64'(res_if.res_errors), 64'(e.errors));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      case (rx_mode)
         1: begin rx_bit_valid = 1'b1; rx_bit_err = (vcnt % 10 == 9); vcnt++; end
         2: begin rx_bit_valid = 1'b1; rx_bit_err = 1'b1; end
         3: begin rx_bit_valid = 1'b1; rx_bit_err = 1'b0; end
         default: ;
      endcase
   endtask

   task automatic cfg_write(input int a, input int d);
      cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = 8'(d);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start(input int n, input int t);
      num_points = 4'(n); target_bits = 32'(t); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string tag);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < bound && done_cnt == d0; i++) tick();
      check_eq(tag, 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      int rst_cyc, bad, d0, r0;
      logic prev;
      logic [7:0] nq[$];

      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; num_points = '0;
      target_bits = '0; start = 1'b0; abort = 1'b0; rx_bit_valid = 1'b0; rx_bit_err = 1'b0;
      res_if.res_ready = 1'b0;
      repeat (3) tick();
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_chain_rst", 64'(chain_rst), 64'd1);
      check_eq("rst_chain_en", 64'(chain_en), 64'd0);
      check_eq("rst_noise", 64'(noise_level), 64'd0);
      check_eq("rst_res_valid", 64'(res_if.res_valid), 64'd0);
      check_eq("rst_res_bits", 64'(res_if.res_bits), 64'd0);
      check_eq("rst_res_errors", 64'(res_if.res_errors), 64'd0);
      rst = 1'b0;
      tick();

      // two-point sweep, one error per ten bits
      cfg_write(0, 10);
      cfg_write(1, 40);
      push_exp(0, 100, 10);
      push_exp(1, 100, 10);
      rx_mode = 1; res_if.res_ready = 1'b1;
      pulse_start(2, 100);
      rst_cyc = 0; prev = 1'b0; d0 = done_cnt;
      for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
         if (busy && chain_rst) begin
            rst_cyc++;
            if (!prev) nq.push_back(noise_level);
         end
         prev = busy && chain_rst;
         tick();
      end
      check_eq("sweep_done_once", 64'(done_cnt - d0), 64'd1);
      check_eq("sweep_rst_cycles", 64'(rst_cyc), 64'd8);
      check_eq("sweep_noise_points", 64'(nq.size()), 64'd2);
      if (nq.size() >= 2) begin
         check_eq("sweep_noise_0", 64'(nq[0]), 64'd10);
         check_eq("sweep_noise_1", 64'(nq[1]), 64'd40);
      end
      repeat (5) tick();
      check_eq("sweep_done_no_repeat", 64'(done_cnt - d0), 64'd1);
      check_eq("sweep_idle_busy", 64'(busy), 64'd0);

      // zero-point sweep
      r0 = rv_cnt;
      pulse_start(0, 5);
      check_eq("zero_done", 64'(done), 64'd1);
      check_eq("zero_busy", 64'(busy), 64'd0);
      check_eq("zero_chain_en", 64'(chain_en), 64'd0);
      tick();
      check_eq("zero_done_pulse", 64'(done), 64'd0);
      repeat (5) tick();
      check_eq("zero_no_result", 64'(rv_cnt - r0), 64'd0);

      // result held under back-pressure while rx keeps pulsing
      res_if.res_ready = 1'b0;
      pulse_start(1, 20);
      for (int i = 0; i < 200 && !res_if.res_valid; i++) tick();
      check_eq("hold_reached", 64'(res_if.res_valid), 64'd1);
      bad = 0;
      repeat (20) begin
         tick();
         if (!(res_if.res_valid && res_if.res_point == 3'd0 &&
               res_if.res_bits == 32'd20 && res_if.res_errors == 32'd2)) bad++;
      end
      check_eq("hold_stable", 64'(bad), 64'd0);
      push_exp(0, 20, 2);
      res_if.res_ready = 1'b1;
      wait_done(50, "hold_done");

      // abort after 50 counted bits; table write while busy is dropped
      d0 = done_cnt; r0 = rv_cnt;
      pulse_start(2, 100);
      cfg_write(0, 77);
      repeat (69) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_chain_rst", 64'(chain_rst), 64'd1);
      check_eq("abort_chain_en", 64'(chain_en), 64'd0);
      check_eq("abort_res_valid", 64'(res_if.res_valid), 64'd0);
      repeat (5) tick();
      check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check_eq("abort_no_result", 64'(rv_cnt - r0), 64'd0);
      push_exp(0, 30, 3);
      pulse_start(1, 30);
      check_eq("rerun_noise", 64'(noise_level), 64'd10);
      wait_done(200, "rerun_done");

      // cycle-exact timing; pulses in FLUSH carry errors that must not count
      rx_mode = 0; rx_bit_valid = 1'b0; rx_bit_err = 1'b0;
      tick();
      push_exp(0, 6, 1);
      pulse_start(1, 6);
      check_eq("t_rst_first", 64'(chain_rst && busy), 64'd1);
      for (int c = 2; c <= 30; c++) begin
         tick();
         if (c == 4)  check_eq("t_rst_last", 64'(chain_rst), 64'd1);
         if (c == 5)  check_eq("t_flush_first", 64'({chain_rst, chain_en}), 64'd1);
         if (c == 26) check_eq("t_no_report_yet", 64'(res_if.res_valid), 64'd0);
         if (c == 27) check_eq("t_report", 64'(res_if.res_valid), 64'd1);
         rx_bit_valid = (c >= 10 && c <= 26);
         rx_bit_err   = (c >= 10 && c <= 21);
      end
      rx_bit_valid = 1'b0; rx_bit_err = 1'b0;

      // over-range point count clamps to 8; target 0 acts as 1
      rx_mode = 3;
      for (int i = 0; i < 8; i++) push_exp(i, 1, 0);
      pulse_start(15, 0);
      wait_done(1000, "clamp_done");

`ifdef BER_EARLY_STOP_EN
      rx_mode = 2;
      push_exp(0, 5, 5);
      pulse_start(1, 1000);
      wait_done(200, "early_stop_done");
`endif

      // reset mid-sweep clears the table and emits nothing
      rx_mode = 1; d0 = done_cnt; r0 = rv_cnt;
      pulse_start(2, 100);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check_eq("mid_rst_busy", 64'(busy), 64'd0);
      check_eq("mid_rst_noise", 64'(noise_level), 64'd0);
      repeat (5) tick();
      check_eq("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
      check_eq("mid_rst_no_result", 64'(rv_cnt - r0), 64'd0);

      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
